// File: rtl/scm_stream_fifo.sv
// rtl/scm_stream_fifo.sv - valid/ready streaming FIFO on a 1R1W register file with registered output
//
// register_file_1r_1w: DEPTH x DATA_WIDTH storage, synchronous write, combinational read.
//   clk                 clock
//   ReadEnable          read strobe (ReadData is zero when low)
//   ReadAddr, ReadData  read address / combinational read data
//   WriteEnable         write strobe
//   WriteAddr, WriteData write address / data, captured on rising edge
//
// scm_stream_fifo: elastic buffer, capacity 2**ADDR_WIDTH + 1 (storage plus output register).
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             synchronous clear, overrides push/pop in its cycle
//   in_valid_i/in_ready_o/in_data_i      producer handshake and payload
//   out_valid_o/out_ready_i/out_data_o   consumer handshake and registered payload
//   count_o             entries held (storage + output register)

module register_file_1r_1w #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset; the FIFO never reads an unwritten slot.
  always_ff @(posedge clk) begin
    if (WriteEnable) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  assign ReadData = ReadEnable ? mem[ReadAddr] : '0;

endmodule

module scm_stream_fifo #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   occ;
  logic                  storage_empty;
  logic                  storage_full;
  logic                  push;
  logic                  pop;
  logic                  fetch;
  logic [DATA_WIDTH-1:0] rd_data;

  assign occ           = wr_ptr - rd_ptr;
  assign storage_empty = (wr_ptr == rd_ptr);
  assign storage_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                         (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // Depends on registered pointers only, so no path from out_ready_i.
  assign in_ready_o = !storage_full;

  // Flush suppresses the storage write and the fetch of its cycle.
  assign push  = in_valid_i & in_ready_o & !flush_i;
  assign pop   = out_valid_o & out_ready_i;
  assign fetch = !storage_empty & (!out_valid_o | out_ready_i) & !flush_i;

  assign count_o = occ + {{ADDR_WIDTH{1'b0}}, out_valid_o};

  register_file_1r_1w #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_storage (
    .clk         (clk),
    .ReadEnable  (fetch),
    .ReadAddr    (rd_ptr[ADDR_WIDTH-1:0]),
    .ReadData    (rd_data),
    .WriteEnable (push),
    .WriteAddr   (wr_ptr[ADDR_WIDTH-1:0]),
    .WriteData   (in_data_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (flush_i) begin
      // out_data_o is intentionally held across a flush.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fetch) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        out_valid_o <= 1'b1;
        out_data_o  <= rd_data;
      end else if (pop) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scm_stream_fifo.sv
// tb/tb_scm_stream_fifo.sv - self-checking bench for scm_stream_fifo against a queue model
module tb_scm_stream_fifo;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [AW:0]   count_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: items waiting in storage, plus the output register.
  logic [DW-1:0] sq[$];
  logic          ov;
  logic [DW-1:0] od;

  scm_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    ov = 1'b0;
    od = '0;
  endtask

  task automatic check_outputs(input string phase);
    chk({phase, ":in_ready"},  in_ready_o,  (sq.size() < DEPTH));
    chk({phase, ":out_valid"}, out_valid_o, ov);
    chk({phase, ":out_data"},  out_data_o,  od);
    chk({phase, ":count"},     count_o,     sq.size() + int'(ov));
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks mid-cycle,
  // advances the model across the edge, returns at the next posedge+1.
  task automatic cycle(input string phase, input logic v, input logic [DW-1:0] d,
                       input logic r, input logic f);
    logic push_m;
    logic fetch_m;
    in_valid_i  = v;
    in_data_i   = v ? d : 'x;
    out_ready_i = r;
    flush_i     = f;
    #4;
    check_outputs(phase);
    push_m  = v && (sq.size() < DEPTH);
    fetch_m = (sq.size() > 0) && (!ov || r);
    @(posedge clk);
    if (f) begin
      sq.delete();
      ov = 1'b0;
    end else begin
      if (fetch_m) begin
        od = sq.pop_front();
        ov = 1'b1;
      end else if (ov && r) begin
        ov = 1'b0;
      end
      if (push_m) sq.push_back(d);
    end
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset:out_valid", out_valid_o, 1'b0);
    chk("reset:out_data",  out_data_o,  32'h0);
    chk("reset:count",     count_o,     4'd0);
    rst_n = 1'b1;
    #1;
    chk("reset:in_ready", in_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Single push, latency two cycles.
    cycle("single", 1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    chk("single:t1_count", count_o, 4'd1);
    chk("single:t1_valid", out_valid_o, 1'b0);
    cycle("single", 1'b0, '0, 1'b1, 1'b0);
    chk("single:t2_valid", out_valid_o, 1'b1);
    chk("single:t2_data",  out_data_o,  32'hA5A5_0001);
    chk("single:t2_count", count_o, 4'd1);
    cycle("single", 1'b0, '0, 1'b1, 1'b0);
    chk("single:t3_count", count_o, 4'd0);

    // Fill under backpressure: only DEPTH+1 accepted.
    for (int i = 0; i < 10; i++) cycle("fill", 1'b1, i, 1'b0, 1'b0);
    chk("fill:count",    count_o,    4'd9);
    chk("fill:in_ready", in_ready_o, 1'b0);
    for (int i = 0; i < 10; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drain:count", count_o, 4'd0);

    // Continuous streaming, pointer wrap many times over.
    for (int i = 0; i < 100; i++) cycle("stream", 1'b1, 32'h1000 + i, 1'b1, 1'b0);
    chk("stream:count", count_o, 4'd2);
    for (int i = 0; i < 4; i++) cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0);

    // Random backpressure.
    for (int i = 0; i < 10000; i++) begin
      cycle("random", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 12; i++) cycle("random_drain", 1'b0, '0, 1'b1, 1'b0);

    // Flush with five entries held and push+pop active.
    for (int i = 0; i < 5; i++) cycle("preflush", 1'b1, 32'h5000 + i, 1'b0, 1'b0);
    chk("preflush:count", count_o, 4'd5);
    cycle("flush", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("flush:count",     count_o,     4'd0);
    chk("flush:out_valid", out_valid_o, 1'b0);
    chk("flush:in_ready",  in_ready_o,  1'b1);
    for (int i = 0; i < 3; i++) cycle("postflush", 1'b1, 32'h6000 + i, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("postflush_drain", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges mid-stream.
    for (int i = 0; i < 6; i++) cycle("prereset", 1'b1, 32'h7000 + i, 1'b0, 1'b0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset:out_valid", out_valid_o, 1'b0);
    chk("async_reset:out_data",  out_data_o,  32'h0);
    chk("async_reset:count",     count_o,     4'd0);
    chk("async_reset:in_ready",  in_ready_o,  1'b1);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cycle("postreset", 1'b1, 32'h8000 + i, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("postreset_drain", 1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
